// File: rtl/bme_irq_pkg.sv
// Shared definitions for the BME data-ready interrupt servicer:
// one-hot state encoding, PIO register offsets and mask write values.
package bme_irq_pkg;

    typedef enum logic [8:0] {
        ST_INIT  = 9'b0_0000_0001,
        ST_IDLE  = 9'b0_0000_0010,
        ST_MASK  = 9'b0_0000_0100,
        ST_RD    = 9'b0_0000_1000,
        ST_CAP   = 9'b0_0001_0000,
        ST_EMIT  = 9'b0_0010_0000,
        ST_PRD   = 9'b0_0100_0000,
        ST_PCAP  = 9'b0_1000_0000,
        ST_REARM = 9'b1_0000_0000
    } state_e;

    localparam logic [1:0]  ADDR_DATA = 2'd0;
    localparam logic [1:0]  ADDR_MASK = 2'd2;

    localparam logic [31:0] MASK_ON   = 32'd1;
    localparam logic [31:0] MASK_OFF  = 32'd0;

endpackage

// File: rtl/bme_irq_servicer.sv
// BME sensor data-ready interrupt servicer (Avalon-MM master on the sensor PIO).
// Converts the level interrupt into exactly one handshaked event per sensor
// pulse: mask, confirm by reading the line, emit, poll until the line drops,
// re-arm the mask.
// Optional build macro: BME_IRQ_TIMEOUT_EN adds a poll watchdog that gives up
// after TIMEOUT_CYCLES and raises a sticky timeout flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | write mask=1 once the first clock after reset release is seen
// IDLE  | armed, waiting for irq
// MASK  | write mask=0 so the level cannot retrigger while servicing
// RD    | read the data register (line level)
// CAP   | read data valid; line high -> EMIT, low -> spurious, REARM
// EMIT  | event_valid held until event_ready
// PRD   | poll read of the data register
// PCAP  | poll capture; line high -> PRD, low (or watchdog) -> REARM
// REARM | write mask=1, back to IDLE
module bme_irq_servicer
    import bme_irq_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             irq,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [CNT_W-1:0] event_count,
    output logic [CNT_W-1:0] spurious_count,
    output logic             timeout
);

    state_e           state_q, state_d;
    logic             rel_q, rel_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0] spur_cnt_q, spur_cnt_d;
    logic             line;
    logic             tmo_fire;
    logic [30:0]      unused_rdata;

    assign line         = avm_readdata[0];
    assign unused_rdata = avm_readdata[31:1];

`ifdef BME_IRQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            tmo_q, tmo_d;
    logic            in_poll_q;
    logic            in_poll_d;

    assign in_poll_q = (state_q == ST_PRD) || (state_q == ST_PCAP);
    assign in_poll_d = (state_d == ST_PRD) || (state_d == ST_PCAP);
    // Terminal count reached in the last allowed poll cycle, unless that
    // very cycle already captured the line low.
    assign tmo_fire  = in_poll_q && (wd_q == '0) && !((state_q == ST_PCAP) && !line);

    // Watchdog: load on PRD entry, count down while polling, clear on exit.
    always_comb begin
        wd_d  = wd_q;
        tmo_d = tmo_q;
        if (in_poll_d) begin
            if (!in_poll_q) begin
                wd_d = WD_W'(TIMEOUT_CYCLES - 1);
            end else if (wd_q != '0) begin
                wd_d = wd_q - 1'b1;
            end
        end else begin
            wd_d = '0;
        end
        if (tmo_fire) begin
            tmo_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_fire       = 1'b0;
    assign timeout        = 1'b0;
`endif

    // Next-state and counter updates.
    always_comb begin
        state_d    = state_q;
        rel_d      = 1'b1;
        evt_cnt_d  = evt_cnt_q;
        spur_cnt_d = spur_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (rel_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (irq) begin
                    state_d = ST_MASK;
                end
            end
            ST_MASK: state_d = ST_RD;
            ST_RD:   state_d = ST_CAP;
            ST_CAP: begin
                if (line) begin
                    state_d = ST_EMIT;
                end else begin
                    spur_cnt_d = spur_cnt_q + 1'b1;
                    state_d    = ST_REARM;
                end
            end
            ST_EMIT: begin
                if (event_ready) begin
                    evt_cnt_d = evt_cnt_q + 1'b1;
                    state_d   = ST_PRD;
                end
            end
            ST_PRD: begin
                state_d = tmo_fire ? ST_REARM : ST_PCAP;
            end
            ST_PCAP: begin
                state_d = (tmo_fire || !line) ? ST_REARM : ST_PRD;
            end
            ST_REARM: state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    // Bus and event outputs decoded from the current state. The INIT write
    // is held back until the first edge after reset release so that the
    // outputs sit at their idle values while reset is asserted.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = ADDR_DATA;
        avm_writedata  = MASK_OFF;
        event_valid    = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (rel_q) begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = ADDR_MASK;
                    avm_writedata  = MASK_ON;
                end
            end
            ST_MASK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_MASK;
                avm_writedata  = MASK_OFF;
            end
            ST_REARM: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_MASK;
                avm_writedata  = MASK_ON;
            end
            ST_RD, ST_PRD: begin
                avm_chipselect = 1'b1;
            end
            ST_EMIT: begin
                event_valid = 1'b1;
            end
            default: begin
                avm_chipselect = 1'b0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            rel_q      <= 1'b0;
            evt_cnt_q  <= '0;
            spur_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rel_q      <= rel_d;
            evt_cnt_q  <= evt_cnt_d;
            spur_cnt_q <= spur_cnt_d;
        end
    end

    assign event_count    = evt_cnt_q;
    assign spurious_count = spur_cnt_q;

endmodule

// File: doc/bme_irq_servicer.md
# bme_irq_servicer

Avalon-MM master that services the BME sensor data-ready interrupt PIO (single input bit at offset 0, interrupt mask at offset 2, level IRQ = data & mask, fixed one-cycle registered read latency, no waitrequest). On IRQ it masks the interrupt and confirms the level by reading the data register. It then emits one event token to downstream logic, polls until the sensor line drops, and re-arms the mask. It sits beside the Nios in the data collector system and turns the level interrupt into exactly one handshaked event per sensor pulse.

## Interface
- CNT_W, 16, width of event and spurious counters
- TIMEOUT_CYCLES, 1000000, poll watchdog limit in clk cycles (used only with BME_IRQ_TIMEOUT_EN)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- avm_address  out  2  PIO register offset
- avm_chipselect  out  1  PIO select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  32  write data (mask value in bit 0)
- avm_readdata  in  32  PIO read data (bit 0 = sensor line)
- irq  in  1  PIO interrupt output
- event_valid  out  1  one event pending
- event_ready  in  1  downstream accepts event
- event_count  out  CNT_W  accepted events, wraps
- spurious_count  out  CNT_W  IRQs not confirmed by read, wraps
- timeout  out  1  sticky watchdog flag (tied 0 without BME_IRQ_TIMEOUT_EN)

## Operation
- The state register is one-hot. Bus outputs are decoded from the state. Idle bus: chipselect 0, write_n 1, address 0, writedata 0.
- INIT: write mask=1 (addr 2, writedata 1), then IDLE.
- IDLE: wait for irq=1, then MASK.
- MASK: write mask=0, then RD.
- RD: chipselect 1, write_n 1, addr 0, then CAP.
- CAP: address held 0, chipselect 0. Sample avm_readdata[0].
  - If 1: go to EMIT.
  - If 0: increment spurious_count and go to REARM.
- EMIT: event_valid=1 until event_ready. On acceptance, increment event_count, then go to PRD.
- PRD/PCAP: same read pair as RD/CAP. Repeat while bit 0 = 1. When bit 0 = 0, go to REARM.
- REARM: write mask=1, then IDLE.
- irq is ignored outside IDLE. The mask is 0 from MASK through PCAP, so no retrigger can occur.
- Counters wrap at 2^CNT_W. No saturation.
- Reset mid-operation: every output returns to its reset value and the FSM restarts at INIT. A pending event is dropped and not counted.

## Timing
- Reset values: avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, event_valid 0, event_count 0, spurious_count 0, timeout 0. State = INIT.
- The INIT write occurs in the first cycle after reset release.
- irq is sampled high at edge k. Then:
  - MASK occupies cycle k→k+1.
  - RD occupies k+1→k+2.
  - Data is captured at edge k+3.
  - event_valid rises at k+3 (3-cycle latency).
- event_valid is asserted with event_ready already high: accepted at the next edge, so valid is high for one cycle.
- Each poll iteration takes 2 cycles. After line low is captured, REARM takes 1 cycle, and irq can be accepted on the following edge.

## Configuration
- BME_IRQ_TIMEOUT_EN defined:
  - A cycle counter runs from PRD entry.
  - If it reaches TIMEOUT_CYCLES before line low is seen, set timeout (sticky until reset) and go to REARM.
  - The counter clears on leaving PRD/PCAP.
- BME_IRQ_TIMEOUT_EN undefined: no counter, timeout tied 0, polling is unbounded.

## Structure
- Package bme_irq_pkg holds:
  - the state enum;
  - PIO offsets ADDR_DATA=2'd0 and ADDR_MASK=2'd2;
  - the MASK_ON/MASK_OFF constants.
- Single module. No sub-module is warranted; the watchdog counter stays inline under the macro.

## Test plan
- Reset release, PIO model attached → one write addr 2 data 1 in cycle 1, then IDLE; mask reads back 1.
- Line pulse high 10 cycles, event_ready=1 → mask write 0, event_valid rises 3 cycles after irq, event_count=1, mask rearmed after line low, no second event.
- Line high, event_ready held 0 for 20 cycles → event_valid stays high 20 cycles with no further bus reads; count increments once on ready.
- irq forced high for 1 cycle with line already 0 at read → spurious_count=1, event_count=0, mask rearmed.
- reset_n pulsed low during EMIT → outputs at reset values, event_count=0, INIT write reissued.
- With BME_IRQ_TIMEOUT_EN, TIMEOUT_CYCLES=50, line stuck high → timeout=1 within 52 cycles of PRD entry, mask rearmed, irq retriggers.
